// File: rtl/gray_arb_pkg.sv
// Shared constants and state type for the Gray-converter arbiter.
// The optional GRAY_ARB_PARITY_EN build adds a registered parity output.
package gray_arb_pkg;

    localparam int unsigned NReqDefault = 4;
    localparam int unsigned WDefault    = 4;
    localparam int unsigned IdWDefault  = $clog2(NReqDefault);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Requester/consumer bundle for gray_conv_arbiter; slave is the arbiter side.
// out_par exists only when GRAY_ARB_PARITY_EN is defined.
interface gray_conv_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
);
    localparam int unsigned IdW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_bin;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_gray;
    logic [IdW-1:0]    out_id;
    logic              busy;
`ifdef GRAY_ARB_PARITY_EN
    logic              out_par;
`endif

    modport master (
        output req_valid, req_bin, out_ready,
        input  req_ready, out_valid, out_gray, out_id, busy
`ifdef GRAY_ARB_PARITY_EN
        , input out_par
`endif
    );

    modport slave (
        input  req_valid, req_bin, out_ready,
        output req_ready, out_valid, out_gray, out_id, busy
`ifdef GRAY_ARB_PARITY_EN
        , output out_par
`endif
    );

endinterface

// File: rtl/gray_conv_arbiter_bin2gray.sv
// Combinational binary-to-Gray converter.
module bin2gray #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one bin2gray among NREQ requesters; result held until accepted.
// GRAY_ARB_PARITY_EN adds out_par, the registered XOR of out_gray.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int unsigned NREQ = NReqDefault,
    parameter int unsigned W    = WDefault
) (
    input logic                clk,
    input logic                rst,
    gray_conv_arbiter_if.slave bus
);

    localparam int unsigned IdW = $clog2(NREQ);

    state_e         state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] id_q, id_d;
    logic [W-1:0]   gray_q, gray_d;
`ifdef GRAY_ARB_PARITY_EN
    logic           par_q, par_d;
`endif

    logic [NREQ-1:0] rot_valid;
    logic [IdW-1:0]  pick_k;
    logic [IdW-1:0]  grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic            grant;
    logic [W-1:0]    grant_bin;
    logic [W-1:0]    grant_gray;

    // Rotate so the pointer position lands at bit 0, pick lowest, rotate back.
    always_comb begin
        int unsigned idx;
        int unsigned sum;
        rot_valid = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = k + 32'(ptr_q);
            if (idx >= NREQ) idx = idx - NREQ;
            rot_valid[k] = bus.req_valid[idx];
        end
        grant_any = 1'b0;
        pick_k    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_any = 1'b1;
                pick_k    = IdW'(k);
            end
        end
        sum = 32'(pick_k) + 32'(ptr_q);
        if (sum >= NREQ) sum = sum - NREQ;
        grant_idx = IdW'(sum);
    end

    assign can_accept = (state_q == StIdle) | ((state_q == StHold) & bus.out_ready);
    assign grant      = can_accept & grant_any & ~rst;
    assign grant_bin  = bus.req_bin[grant_idx*W +: W];

    bin2gray #(
        .W (W)
    ) u_bin2gray (
        .bin_i  (grant_bin),
        .gray_o (grant_gray)
    );

    always_comb begin
        bus.req_ready = '0;
        if (grant) bus.req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        gray_d  = gray_q;
`ifdef GRAY_ARB_PARITY_EN
        par_d   = par_q;
`endif
        if (grant) begin
            state_d = StHold;
            gray_d  = grant_gray;
            id_d    = grant_idx;
`ifdef GRAY_ARB_PARITY_EN
            par_d   = ^grant_gray;
`endif
            if (32'(grant_idx) == NREQ - 1) ptr_d = '0;
            else                            ptr_d = grant_idx + 1'b1;
        end else if ((state_q == StHold) && bus.out_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            gray_q  <= '0;
`ifdef GRAY_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gray_q  <= gray_d;
`ifdef GRAY_ARB_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.out_valid = (state_q == StHold);
    assign bus.busy      = (state_q == StHold);
    assign bus.out_gray  = gray_q;
    assign bus.out_id    = id_q;
`ifdef GRAY_ARB_PARITY_EN
    assign bus.out_par   = par_q;
`endif

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-Gray converter among NREQ requesters. Each requester offers a W-bit binary word with a valid/ready handshake. The block grants one requester per cycle, converts the word and holds the registered Gray result with the winning requester's ID until the consumer accepts it. It sits between the counter/pointer producers and the Gray-coded pointer consumers (CDC synchronisers, status logic).

## Interface
- NREQ, 4: number of requesters; 2..8.
- W, 4: binary/Gray word width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i offers a word.
- req_bin  in  NREQ*W  requester i word occupies bits [i*W +: W].
- req_ready  out  NREQ  one-hot grant; combinational from state and req_valid.
- out_valid  out  1  registered result valid.
- out_ready  in  1  consumer accepts the result.
- out_gray  out  W  registered Gray code of the granted word.
- out_id  out  $clog2(NREQ)  index of the granted requester.
- busy  out  1  equals out_valid.

## Operation
- States: IDLE (no result held) and HOLD (result held, out_valid=1).
- can_accept = (state==IDLE) | (state==HOLD & out_ready).
- Grant: when can_accept and any req_valid, search round-robin starting at pointer ptr and take the first valid index i. Assert req_ready[i] only. A transfer on requester i is req_valid[i] & req_ready[i].
- On a grant:
  - out_gray <= b ^ (b>>1), where b = req_bin[i].
  - out_id <= i.
  - out_valid <= 1.
  - ptr <= (i+1) mod NREQ.
  - state <= HOLD.
- HOLD with out_ready and no grant: out_valid <= 0, state <= IDLE.
- HOLD without out_ready: all outputs stable and req_ready all 0.
- IDLE with no req_valid: nothing changes and ptr holds.
- Requesters keep valid and data stable until ready. The arbiter makes no commitment to a requester that drops valid before it is granted.
- Reset values:
  - out_valid 0, out_gray 0, out_id 0, busy 0.
  - ptr 0, state IDLE.
  - req_ready 0 while rst is high.
- Reset asserted mid-transaction discards the held result. No grant is issued while rst is high.

## Timing
- Latency: grant in cycle N gives out_valid/out_gray/out_id in cycle N+1.
- Throughput: one result per cycle when out_ready is held high. A grant and a result acceptance in the same cycle are legal: the old result leaves and the new one loads on the same edge.
- Fairness: a continuously valid requester is granted within NREQ grants.
- out_ready arriving while out_valid=0 has no effect.
- Only req_ready has a combinational path (from req_valid and out_ready). All other outputs come straight from flops.

## Configuration
- GRAY_ARB_PARITY_EN defined: adds output out_par (out, 1). It is registered together with out_gray and equals the XOR of all bits of the new out_gray. Reset value 0.
- Without the macro: the port and its flop are absent. All other behaviour is identical.

## Structure
- Package gray_arb_pkg holds:
  - default NREQ and W constants;
  - state enum {IDLE, HOLD};
  - the ID width localparam derived as $clog2(NREQ).
- Sub-module bin2gray: parameterised W, purely combinational, g = b ^ (b>>1). Instantiated once on the muxed granted word.
- Round-robin search stays in the top module as a rotate / priority-pick / rotate-back.

## Test plan
- Single request: req_valid=4'b0100, req_bin[2]=4'b1011, out_ready=1. Expect req_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_gray=4'b1110, out_id=2; ptr becomes 3.
- Round-robin: after reset all four valid with words 0000/0111/1000/1111, out_ready=1. Expect grants 0,1,2,3,0 on consecutive cycles and outputs 0000, 0100, 1100, 1000, 0000.
- Backpressure: hold a result with out_ready=0 for 5 cycles while req_valid=4'b1111. Expect req_ready=0 and outputs stable throughout. Raising out_ready gives an accept and a new grant on the same edge.
- Idle gap: out_ready=1 and a single req1 word 4'b1111 accepted, then req_valid=0. Expect out_valid=1 for exactly one cycle, then 0, with ptr=2 held.
- Reset mid-HOLD: assert rst asynchronously while out_valid=1. Expect out_valid, out_gray, out_id and req_ready at 0 immediately. After release, the first grant goes to the lowest valid index from 0.
- Parity (GRAY_ARB_PARITY_EN): word 4'b1011 gives gray 1110 and out_par=1. Word 4'b0111 gives gray 0100 and out_par=1. Word 4'b1111 gives gray 1000 and out_par=1.
